// File: rtl/adc_cap_scheduler_pkg.sv
// adc_cap_pkg: FSM states, S2MM command/status field positions and the command packer for adc_cap_scheduler
package adc_cap_pkg;
  typedef enum logic [2:0] {IDLE, CALC, ISSUE, DRAIN, DONE} state_t;
  localparam int CMD_BTT_W = 23;
  localparam int CMD_TYPE_BIT = 23;
  localparam int CMD_DSA_LSB = 24;
  localparam int CMD_EOF_BIT = 30;
  localparam int CMD_DRR_BIT = 31;
  localparam int CMD_SADDR_LSB = 32;
  localparam int STS_OKAY = 7;
  localparam int STS_SLVERR = 6;
  localparam int STS_DECERR = 5;
  localparam int STS_INTERR = 4;
  function automatic logic [103:0] pack_s2mm_cmd(input int aw, input logic [3:0] tag, input logic [63:0] saddr, input logic eof, input logic [CMD_BTT_W-1:0] btt);
    logic [103:0] c;
    c = {40'b0, saddr} << CMD_SADDR_LSB;
    c = c | ({100'b0, tag} << (aw + CMD_SADDR_LSB));
    c[CMD_EOF_BIT] = eof;
    c[CMD_TYPE_BIT] = 1'b1;
    c[CMD_BTT_W-1:0] = btt;
    return c;
  endfunction
endpackage

// File: rtl/adc_cap_scheduler_if.sv
// adc_cap_scheduler_if: S2MM command/status streams; master = scheduler, slave = datamover
interface adc_cap_scheduler_if #(parameter int ADDR_WIDTH = 40);
  logic cmd_tvalid, cmd_tready, sts_tvalid, sts_tready;
  logic [ADDR_WIDTH+39:0] cmd_tdata;
  logic [7:0] sts_tdata;
  modport master(output cmd_tvalid, cmd_tdata, sts_tready, input cmd_tready, sts_tvalid, sts_tdata);
  modport slave(input cmd_tvalid, cmd_tdata, sts_tready, output cmd_tready, sts_tvalid, sts_tdata);
endinterface

// File: rtl/adc_cap_scheduler.sv
// adc_cap_scheduler: splits a capture request (ps_clk/ps_rst, write_start/write_reset, start_address, cap_size) into chunked S2MM commands on dm, checks statuses, reports current_addr/datamover_status/wr_mm2s_err/cap_done/busy; ADC_CAP_CYCLE_CNT_EN enables the run_cycles counter
module adc_cap_scheduler import adc_cap_pkg::*; #(
  parameter int ADDR_WIDTH = 40,
  parameter int BTT_WIDTH = 23,
  parameter int CHUNK_BYTES = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  ps_clk,
  input  logic                  ps_rst,
  input  logic                  write_start,
  input  logic                  write_reset,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [31:0]           cap_size,
  adc_cap_scheduler_if.master   dm,
  output logic [ADDR_WIDTH-1:0] current_addr,
  output logic [7:0]            datamover_status,
  output logic                  wr_mm2s_err,
  output logic                  cap_done,
  output logic                  busy,
  output logic [31:0]           run_cycles
);
  localparam int CW = $clog2(CHUNK_BYTES);
  state_t state, next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0] remain, room, chunk_btt;
  logic [BTT_WIDTH-1:0] btt;
  logic eof;
  logic [3:0] tag, exp_tag, outstanding;
  logic rst, start, cmd_hs, sts_live, sts_take, sts_bad;
  assign rst = ps_rst | write_reset;
  assign start = write_start && (state == IDLE || state == DONE);
  assign cmd_hs = dm.cmd_tvalid && dm.cmd_tready;
  assign sts_live = dm.sts_tvalid && state != IDLE;
  assign sts_take = sts_live && outstanding != '0;
  assign sts_bad = !dm.sts_tdata[STS_OKAY] || (|dm.sts_tdata[STS_SLVERR:STS_INTERR]) || dm.sts_tdata[3:0] != exp_tag;
  assign room = 32'(CHUNK_BYTES) - 32'(addr[CW-1:0]);
  assign chunk_btt = remain < room ? remain : room;
  assign dm.sts_tready = 1'b1;
  assign dm.cmd_tvalid = state == ISSUE && remain != '0 && outstanding < 4'(MAX_OUTSTANDING);
  assign dm.cmd_tdata = dm.cmd_tvalid ? (ADDR_WIDTH+40)'(pack_s2mm_cmd(ADDR_WIDTH, tag, 64'(addr), eof, CMD_BTT_W'(btt))) : '0;
  assign current_addr = addr;
  always_ff @(posedge ps_clk) state <= rst ? IDLE : next;
  always_comb begin
    next = state;
    if (start) next = CALC;
    else
      case (state)
        CALC:    next = remain == '0 ? DRAIN : ISSUE;
        ISSUE:   next = (cmd_hs || remain == '0) ? CALC : ISSUE;
        DRAIN:   next = outstanding == '0 ? DONE : DRAIN;
        default: next = state;
      endcase
    cap_done = state == DONE;
    busy = state inside {CALC, ISSUE, DRAIN};
  end
  always_ff @(posedge ps_clk) begin
    if (rst) begin
      addr <= '0;
      remain <= '0;
      btt <= '0;
      eof <= 1'b0;
      tag <= '0;
      exp_tag <= '0;
      outstanding <= '0;
      datamover_status <= '0;
      wr_mm2s_err <= 1'b0;
    end else if (start) begin
      addr <= start_address & ~ADDR_WIDTH'('hF);
      remain <= cap_size & ~32'hF;
      tag <= '0;
      exp_tag <= '0;
      outstanding <= '0;
      wr_mm2s_err <= 1'b0;
    end else begin
      if (state == CALC) begin
        btt <= BTT_WIDTH'(chunk_btt);
        eof <= chunk_btt == remain;
      end
      if (cmd_hs) begin
        addr <= addr + ADDR_WIDTH'(btt);
        remain <= remain - 32'(btt);
        tag <= tag + 4'd1;
      end
      if (sts_live && (outstanding == '0 || sts_bad)) wr_mm2s_err <= 1'b1;
      if (sts_take) begin
        datamover_status <= dm.sts_tdata;
        exp_tag <= exp_tag + 4'd1;
        if (sts_bad) remain <= '0;
      end
      outstanding <= outstanding + 4'(cmd_hs) - 4'(sts_take);
    end
  end
`ifdef ADC_CAP_CYCLE_CNT_EN
  always_ff @(posedge ps_clk)
    if (rst || start) run_cycles <= '0;
    else if (busy && !(&run_cycles)) run_cycles <= run_cycles + 32'd1;
`else
  assign run_cycles = '0;
`endif
endmodule

// File: tb/tb_adc_cap_scheduler.sv
// tb_adc_cap_scheduler: table-driven and directed checks of adc_cap_scheduler with a queued status responder
module tb_adc_cap_scheduler;
  logic ps_clk = 1'b0;
  logic ps_rst = 1'b1, write_start = 1'b0, write_reset = 1'b0;
  logic [39:0] start_address = '0;
  logic [31:0] cap_size = '0;
  logic [39:0] current_addr;
  logic [7:0] datamover_status;
  logic wr_mm2s_err, cap_done, busy;
  logic [31:0] run_cycles;
  logic auto_sts = 1'b0;
  logic [79:0] cmds[$];
  logic [7:0] sts_q[$];
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic [39:0] addr;
    logic [31:0] size;
    int          ncmd;
    logic [39:0] end_addr;
    logic [22:0] first_btt;
    logic [22:0] last_btt;
  } vec_t;
  adc_cap_scheduler_if #(.ADDR_WIDTH(40)) dm();
  adc_cap_scheduler #(.ADDR_WIDTH(40), .BTT_WIDTH(23), .CHUNK_BYTES(4096), .MAX_OUTSTANDING(4)) dut (
    .ps_clk(ps_clk), .ps_rst(ps_rst), .write_start(write_start), .write_reset(write_reset),
    .start_address(start_address), .cap_size(cap_size), .dm(dm),
    .current_addr(current_addr), .datamover_status(datamover_status), .wr_mm2s_err(wr_mm2s_err),
    .cap_done(cap_done), .busy(busy), .run_cycles(run_cycles)
  );
  always #5 ps_clk = ~ps_clk;
  always @(negedge ps_clk)
    if (dm.cmd_tvalid && dm.cmd_tready) begin
      cmds.push_back(dm.cmd_tdata);
      if (auto_sts) sts_q.push_back({4'h8, dm.cmd_tdata[75:72]});
    end
  initial begin
    dm.sts_tvalid = 1'b0;
    dm.sts_tdata = '0;
    forever begin
      @(posedge ps_clk);
      #2;
      dm.sts_tvalid = sts_q.size() > 0;
      dm.sts_tdata = dm.sts_tvalid ? sts_q.pop_front() : 8'h0;
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge ps_clk);
      #1;
    end
  endtask
  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [79:0] cmd_at(input int k);
    return k < cmds.size() ? cmds[k] : '0;
  endfunction
  task automatic pulse_start(input logic [39:0] a, input logic [31:0] s);
    start_address = a;
    cap_size = s;
    write_start = 1'b1;
    tick();
    write_start = 1'b0;
  endtask
  task automatic wait_done(input string name, input int budget);
    int i = 0;
    while (!cap_done && i < budget) begin
      tick();
      i++;
    end
    check(name, cap_done, 1);
  endtask
  task automatic check_zero(input string p);
    check({p, " current_addr"}, current_addr, 0);
    check({p, " datamover_status"}, datamover_status, 0);
    check({p, " wr_mm2s_err"}, wr_mm2s_err, 0);
    check({p, " cap_done"}, cap_done, 0);
    check({p, " busy"}, busy, 0);
    check({p, " cmd_tvalid"}, dm.cmd_tvalid, 0);
    check({p, " cmd_tdata"}, dm.cmd_tdata, 0);
    check({p, " run_cycles"}, run_cycles, 0);
  endtask
  initial begin
    vec_t v[5];
    logic [79:0] held, c, p;
    int n;
    v[0] = '{40'h0, 32'd24000, 6, 40'h5DC0, 23'd4096, 23'd3520};
    v[1] = '{40'h0F00, 32'h300, 2, 40'h1200, 23'h100, 23'h200};
    v[2] = '{40'h12345678, 32'h2005, 3, 40'h12347670, 23'h990, 23'h670};
    v[3] = '{40'hFF00001000, 32'h10, 1, 40'hFF00001010, 23'h10, 23'h10};
    v[4] = '{40'h0, 32'h4000, 4, 40'h4000, 23'h1000, 23'h1000};
    dm.cmd_tready = 1'b1;
    tick(3);
    ps_rst = 1'b0;
    check_zero("reset");
    cmds.delete();
    pulse_start(40'h1230, 32'hF);
    check("zero tvalid N+1", dm.cmd_tvalid, 0);
    tick();
    check("zero cap_done N+2", cap_done, 0);
    tick();
    check("zero cap_done N+3", cap_done, 1);
    check("zero busy N+3", busy, 0);
    check("zero ncmd", cmds.size(), 0);
    check("zero current_addr", current_addr, 40'h1230);
`ifdef ADC_CAP_CYCLE_CNT_EN
    check("zero run_cycles", run_cycles, 2);
`else
    check("zero run_cycles", run_cycles, 0);
`endif
    auto_sts = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmds.delete();
      pulse_start(v[i].addr, v[i].size);
      wait_done($sformatf("v%0d done", i), 300);
      n = cmds.size();
      check($sformatf("v%0d ncmd", i), n, v[i].ncmd);
      check($sformatf("v%0d first saddr", i), cmd_at(0)[71:32], v[i].addr & ~40'hF);
      check($sformatf("v%0d first btt", i), cmd_at(0)[22:0], v[i].first_btt);
      check($sformatf("v%0d last btt", i), cmd_at(n - 1)[22:0], v[i].last_btt);
      for (int j = 0; j < n; j++) begin
        c = cmd_at(j);
        check($sformatf("v%0d c%0d tag", i, j), c[75:72], 4'(j));
        check($sformatf("v%0d c%0d eof", i, j), c[30], j == n - 1);
        check($sformatf("v%0d c%0d fixed", i, j), {c[79:76], c[31], c[29:23]}, 12'h001);
        if (j > 0) begin
          p = cmd_at(j - 1);
          check($sformatf("v%0d c%0d saddr", i, j), c[71:32], p[71:32] + 40'(p[22:0]));
        end
      end
      check($sformatf("v%0d current_addr", i), current_addr, v[i].end_addr);
      check($sformatf("v%0d err", i), wr_mm2s_err, 0);
      check($sformatf("v%0d busy", i), busy, 0);
      check($sformatf("v%0d status", i), datamover_status, {4'h8, 4'(v[i].ncmd - 1)});
    end
    auto_sts = 1'b0;
    cmds.delete();
    pulse_start(40'h0, 32'h8000);
    check("lim tvalid N+1", dm.cmd_tvalid, 0);
    tick();
    check("lim tvalid N+2", dm.cmd_tvalid, 1);
    tick(20);
    check("lim ncmd", cmds.size(), 4);
    check("lim tvalid held low", dm.cmd_tvalid, 0);
    check("lim busy", busy, 1);
    check("lim current_addr", current_addr, 40'h4000);
    pulse_start(40'h9000, 32'h40);
    tick(3);
    check("busy start ncmd", cmds.size(), 4);
    check("busy start addr", current_addr, 40'h4000);
    dm.cmd_tready = 1'b0;
    sts_q.push_back(8'h80);
    tick(4);
    check("lim tvalid after sts", dm.cmd_tvalid, 1);
    held = dm.cmd_tdata;
    tick(3);
    check("lim tdata stable", dm.cmd_tdata, held);
    check("lim tvalid stable", dm.cmd_tvalid, 1);
    check("lim ncmd stalled", cmds.size(), 4);
    dm.cmd_tready = 1'b1;
    tick(3);
    check("lim ncmd +1", cmds.size(), 5);
    check("lim cmd4 word", cmd_at(4), held);
    check("lim cmd4 saddr", held[71:32], 40'h4000);
    check("lim cmd4 tag", held[75:72], 4);
    check("lim tvalid low again", dm.cmd_tvalid, 0);
    write_reset = 1'b1;
    tick();
    write_reset = 1'b0;
    check_zero("abort");
    auto_sts = 1'b1;
    cmds.delete();
    pulse_start(40'h100, 32'h40);
    wait_done("abort rerun done", 100);
    check("abort rerun ncmd", cmds.size(), 1);
    check("abort rerun btt", cmd_at(0)[22:0], 23'h40);
    check("abort rerun eof", cmd_at(0)[30], 1);
    check("abort rerun tag", cmd_at(0)[75:72], 0);
    check("abort rerun addr", current_addr, 40'h140);
    check("abort rerun err", wr_mm2s_err, 0);
    auto_sts = 1'b0;
    sts_q.push_back(8'h8F);
    tick(3);
    check("spurious err", wr_mm2s_err, 1);
    check("spurious status ignored", datamover_status, 8'h80);
    check("spurious cap_done", cap_done, 1);
    cmds.delete();
    pulse_start(40'h0, 32'h8000);
    check("err cleared on start", wr_mm2s_err, 0);
    tick(15);
    check("err ncmd 4", cmds.size(), 4);
    sts_q.push_back(8'h80);
    tick(6);
    sts_q.push_back(8'h81);
    tick(6);
    check("err ncmd 6", cmds.size(), 6);
    sts_q.push_back(8'h42);
    tick(10);
    check("err flag", wr_mm2s_err, 1);
    check("err status", datamover_status, 8'h42);
    check("err no more cmds", cmds.size(), 6);
    check("err tvalid", dm.cmd_tvalid, 0);
    check("err draining", cap_done, 0);
    check("err busy", busy, 1);
    sts_q.push_back(8'h83);
    sts_q.push_back(8'h84);
    tick(5);
    check("err still draining", cap_done, 0);
    sts_q.push_back(8'h85);
    tick();
    check("err cap_done M+1", cap_done, 0);
    check("err busy M+1", busy, 1);
    tick();
    check("err cap_done M+2", cap_done, 1);
    check("err busy M+2", busy, 0);
    check("err last status", datamover_status, 8'h85);
    check("err current_addr", current_addr, 40'h6000);
    check("err sticky", wr_mm2s_err, 1);
    check("err final ncmd", cmds.size(), 6);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
